seq_alu: RTL and testbench

- Parametrised, registered successor to the 16-bit combinational ALU, used in the CPU execute stage.
- Single-cycle ops (add, sub, and, or, move) return their result in 1 cycle.
- Signed multiply and divide are iterative (one bit per cycle), so the ALU has a start/done handshake the control FSM stalls on.
- High product half / remainder goes to the r15 output, as in the current ISA.

---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 265 ++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/result bundle between the execute-stage control FSM and seq_alu.
// The master drives the request; the slave (the ALU) returns handshake, results and flags.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] r15;
    logic             of;
    logic             dz;
    logic             ill;

    modport master (
        output in_valid, a, b, op,
        input  in_ready, done, out, r15, of, dz, ill
    );

    modport slave (
        input  in_valid, a, b, op,
        output in_ready, done, out, r15, of, dz, ill
    );
endinterface

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle add/sub/and/or/move, iterative signed mul/div.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise op=011 reports as illegal.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_MUL = 2'b01, S_DIV = 2'b10, S_DONE = 2'b11} state_t;

    state_t             state_r, state_nxt_s;
    logic               ready_r, done_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH:0]     hi_r, mag_r;
    logic [WIDTH-1:0]   lo_r;
    logic               neg_r;
    logic               accept_s, last_s;
    logic [WIDTH-1:0]   abs_a_s, sum_s, diff_s;
    logic [WIDTH:0]     abs_b_s, mul_hi_s;
    logic [WIDTH+1:0]   madd_s;
    logic [WIDTH-1:0]   mul_lo_s;
    logic [2*WIDTH-1:0] pmag_s, prod_s;
    logic               res_load_s, res_of_s, res_dz_s, res_ill_s;
    logic [WIDTH-1:0]   res_out_s, res_r15_s;
    logic [WIDTH-1:0]   out_r, r15_r;
    logic               of_r, dz_r, ill_r;

    assign accept_s = bus.in_valid & ready_r;
    assign last_s   = (cnt_r == CNT_LAST);
    assign sum_s    = bus.a + bus.b;
    assign diff_s   = bus.a - bus.b;

    // |a| fits WIDTH unsigned bits even for MIN; |b| is kept one bit wider as the mul/div operand
    assign abs_a_s = bus.a[WIDTH-1] ? (~bus.a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.a;
    assign abs_b_s = bus.b[WIDTH-1] ? (~{1'b1, bus.b} + {{WIDTH{1'b0}}, 1'b1}) : {1'b0, bus.b};

    assign madd_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : {(WIDTH+2){1'b0}});
    assign mul_hi_s = madd_s[WIDTH+1:1];
    assign mul_lo_s = {madd_s[0], lo_r[WIDTH-1:1]};
    assign pmag_s   = {mul_hi_s[WIDTH-1:0], mul_lo_s};
    assign prod_s   = neg_r ? (~pmag_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : pmag_s;

`ifdef SEQ_ALU_DIV_EN
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_r;
    logic             dzp_r, dovf_r;
    logic [WIDTH:0]   shift_s, div_hi_s;
    logic [WIDTH+1:0] trial_s;
    logic             ge_s;
    logic [WIDTH-1:0] div_lo_s, quot_s, rem_s;

    assign shift_s  = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
    assign trial_s  = {1'b0, shift_s} - {1'b0, mag_r};
    assign ge_s     = ~trial_s[WIDTH+1];
    assign div_hi_s = ge_s ? trial_s[WIDTH:0] : shift_s;
    assign div_lo_s = {lo_r[WIDTH-2:0], ge_s};
    assign quot_s   = neg_r ? (~div_lo_s + {{(WIDTH-1){1'b0}}, 1'b1}) : div_lo_s;
    assign rem_s    = a_r[WIDTH-1] ? (~div_hi_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                                   : div_hi_s[WIDTH-1:0];

    // Divide special cases are decided from the operands at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= ZERO_W;
            dzp_r  <= 1'b0;
            dovf_r <= 1'b0;
        end else if (accept_s) begin
            a_r    <= bus.a;
            dzp_r  <= (bus.b == ZERO_W);
            dovf_r <= (bus.a == MIN_W) && (bus.b == ALL_ONES);
        end else begin
            a_r    <= a_r;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    if (bus.op == OP_MUL) begin
                        state_nxt_s = S_MUL;
`ifdef SEQ_ALU_DIV_EN
                    end else if (bus.op == OP_DIV) begin
                        state_nxt_s = S_DIV;
`endif
                    end else begin
                        state_nxt_s = S_DONE;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register with registered ready/done derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_DONE);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Operand capture and one-bit-per-cycle iteration
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            hi_r  <= {(WIDTH+1){1'b0}};
            lo_r  <= ZERO_W;
            mag_r <= {(WIDTH+1){1'b0}};
            neg_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
            hi_r  <= {(WIDTH+1){1'b0}};
            lo_r  <= abs_a_s;
            mag_r <= abs_b_s;
            neg_r <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end else if (state_r == S_MUL) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            hi_r  <= mul_hi_s;
            lo_r  <= mul_lo_s;
`ifdef SEQ_ALU_DIV_EN
        end else if (state_r == S_DIV) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            hi_r  <= div_hi_s;
            lo_r  <= div_lo_s;
`endif
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result selection: single-cycle ops at acceptance, mul/div on the final iteration
    always_comb begin
        res_load_s = 1'b0;
        res_out_s  = ZERO_W;
        res_r15_s  = ZERO_W;
        res_of_s   = 1'b0;
        res_dz_s   = 1'b0;
        res_ill_s  = 1'b0;
        if (accept_s) begin
            case (bus.op)
                OP_ADD: begin
                    res_load_s = 1'b1;
                    res_out_s  = sum_s;
                    res_of_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_SUB: begin
                    res_load_s = 1'b1;
                    res_out_s  = diff_s;
                    res_of_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_MUL: res_load_s = 1'b0;
                OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
                    res_load_s = 1'b0;
`else
                    res_load_s = 1'b1;
                    res_ill_s  = 1'b1;
`endif
                end
                OP_AND: begin
                    res_load_s = 1'b1;
                    res_out_s  = bus.a & bus.b;
                end
                OP_OR: begin
                    res_load_s = 1'b1;
                    res_out_s  = bus.a | bus.b;
                end
                OP_MOV: begin
                    res_load_s = 1'b1;
                    res_out_s  = bus.b;
                end
                OP_ILL: begin
                    res_load_s = 1'b1;
                    res_ill_s  = 1'b1;
                end
                default: begin
                    res_load_s = 1'b1;
                    res_ill_s  = 1'b1;
                end
            endcase
        end else if ((state_r == S_MUL) && last_s) begin
            res_load_s = 1'b1;
            res_out_s  = prod_s[WIDTH-1:0];
            res_r15_s  = prod_s[2*WIDTH-1:WIDTH];
            res_of_s   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
`ifdef SEQ_ALU_DIV_EN
        end else if ((state_r == S_DIV) && last_s) begin
            res_load_s = 1'b1;
            if (dzp_r) begin
                res_out_s = ALL_ONES;
                res_r15_s = a_r;
                res_dz_s  = 1'b1;
            end else if (dovf_r) begin
                res_out_s = MIN_W;
                res_of_s  = 1'b1;
            end else begin
                res_out_s = quot_s;
                res_r15_s = rem_s;
            end
`endif
        end else begin
            res_load_s = 1'b0;
        end
    end

    // Result registers hold until the next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r <= ZERO_W;
            r15_r <= ZERO_W;
            of_r  <= 1'b0;
            dz_r  <= 1'b0;
            ill_r <= 1'b0;
        end else if (res_load_s) begin
            out_r <= res_out_s;
            r15_r <= res_r15_s;
            of_r  <= res_of_s;
            dz_r  <= res_dz_s;
            ill_r <= res_ill_s;
        end else begin
            out_r <= out_r;
        end
    end

    assign bus.in_ready = ready_r;
    assign bus.done     = done_r;
    assign bus.out      = out_r;
    assign bus.r15      = r15_r;
    assign bus.of       = of_r;
    assign bus.dz       = dz_r;
    assign bus.ill      = ill_r;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16); divider vectors apply when SEQ_ALU_DIV_EN is defined.
module tb_seq_alu;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   dones;

    seq_alu_if #(.WIDTH(16)) bus ();

    seq_alu #(.WIDTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // lat counts cycles after the acceptance edge; bounded so a missing done cannot hang
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = 16'h0000;
        bus.b        = 16'h0000;
        bus.op       = 3'b000;
        step(3);
        chk("rst.in_ready", bus.in_ready, 1'b1);
        chk("rst.done", bus.done, 1'b0);
        chk("rst.out", bus.out, 16'h0000);
        chk("rst.r15", bus.r15, 16'h0000);
        chk("rst.flags", {bus.of, bus.dz, bus.ill}, 3'b000);
        reset = 1'b0;
        step(1);

        issue(3'b000, 16'h7FFF, 16'h0001);
        wait_done(1, n);
        chk("add_ovf.lat", n, 32'd1);
        chk("add_ovf.out", bus.out, 16'h8000);
        chk("add_ovf.of", bus.of, 1'b1);
        chk("add_ovf.r15", bus.r15, 16'h0000);

        issue(3'b000, 16'h0003, 16'hFFFE);
        wait_done(1, n);
        chk("add2.lat", n, 32'd1);
        chk("add2.out", bus.out, 16'h0001);
        chk("add2.of", bus.of, 1'b0);

        issue(3'b001, 16'h8000, 16'h0001);
        chk("sub_ovf.out", bus.out, 16'h7FFF);
        chk("sub_ovf.of", bus.of, 1'b1);
        step(1);
        chk("done_one_cycle", bus.done, 1'b0);

        issue(3'b010, 16'hFFFD, 16'h0007);
        chk("mul1.busy", bus.in_ready, 1'b0);
        wait_done(1, n);
        chk("mul1.lat", n, 32'd17);
        chk("mul1.out", bus.out, 16'hFFEB);
        chk("mul1.r15", bus.r15, 16'hFFFF);
        chk("mul1.of", bus.of, 1'b0);

        issue(3'b010, 16'h4000, 16'h0004);
        wait_done(1, n);
        chk("mul2.lat", n, 32'd17);
        chk("mul2.r15", bus.r15, 16'h0001);
        chk("mul2.out", bus.out, 16'h0000);
        chk("mul2.of", bus.of, 1'b1);

        issue(3'b010, 16'h8000, 16'h8000);
        wait_done(1, n);
        chk("mul_min.r15", bus.r15, 16'h4000);
        chk("mul_min.out", bus.out, 16'h0000);
        chk("mul_min.of", bus.of, 1'b1);
        step(1);
        chk("mul_min.done_drop", bus.done, 1'b0);
        chk("mul_min.ready", bus.in_ready, 1'b1);

        bus.in_valid = 1'b1;
        bus.op = 3'b100; bus.a = 16'hF0F0; bus.b = 16'hFF00;
        step(1);
        chk("b2b_and.done", bus.done, 1'b1);
        chk("b2b_and.out", bus.out, 16'hF000);
        chk("b2b_and.r15", bus.r15, 16'h0000);
        bus.op = 3'b101;
        step(1);
        chk("b2b_or.done", bus.done, 1'b1);
        chk("b2b_or.out", bus.out, 16'hFFF0);
        bus.op = 3'b110;
        step(1);
        chk("b2b_mov.done", bus.done, 1'b1);
        chk("b2b_mov.out", bus.out, 16'hFF00);
        bus.in_valid = 1'b0;
        step(1);
        chk("b2b.end_done", bus.done, 1'b0);

        issue(3'b010, 16'h0012, 16'hFFFE);
        step(2);
        chk("ign.ready", bus.in_ready, 1'b0);
        bus.op = 3'b000; bus.a = 16'h0001; bus.b = 16'h0001; bus.in_valid = 1'b1;
        step(1);
        bus.in_valid = 1'b0;
        wait_done(4, n);
        chk("ign.lat", n, 32'd17);
        chk("ign.out", bus.out, 16'hFFDC);
        chk("ign.r15", bus.r15, 16'hFFFF);
        chk("ign.of", bus.of, 1'b0);
        step(2);
        chk("ign.no_extra_done", bus.done, 1'b0);
        chk("ign.hold", bus.out, 16'hFFDC);

        issue(3'b010, 16'h0100, 16'h0100);
        step(7);
        reset = 1'b1;
        step(1);
        chk("rst_mid.ready", bus.in_ready, 1'b1);
        chk("rst_mid.done", bus.done, 1'b0);
        chk("rst_mid.out", bus.out, 16'h0000);
        chk("rst_mid.r15", bus.r15, 16'h0000);
        chk("rst_mid.flags", {bus.of, bus.dz, bus.ill}, 3'b000);
        reset = 1'b0;
        dones = 0;
        repeat (20) begin
            step(1);
            if (bus.done === 1'b1) dones++;
        end
        chk("rst_mid.no_done", dones, 32'd0);
        issue(3'b000, 16'h1234, 16'h1111);
        wait_done(1, n);
        chk("rst_add.lat", n, 32'd1);
        chk("rst_add.out", bus.out, 16'h2345);

`ifdef SEQ_ALU_DIV_EN
        issue(3'b011, 16'hFFF9, 16'h0002);
        wait_done(1, n);
        chk("div1.lat", n, 32'd17);
        chk("div1.out", bus.out, 16'hFFFD);
        chk("div1.r15", bus.r15, 16'hFFFF);
        chk("div1.flags", {bus.of, bus.dz, bus.ill}, 3'b000);
        issue(3'b011, 16'h0064, 16'hFFF9);
        wait_done(1, n);
        chk("div2.out", bus.out, 16'hFFF2);
        chk("div2.r15", bus.r15, 16'h0002);
        issue(3'b011, 16'h1234, 16'h0000);
        wait_done(1, n);
        chk("divz.lat", n, 32'd17);
        chk("divz.dz", bus.dz, 1'b1);
        chk("divz.out", bus.out, 16'hFFFF);
        chk("divz.r15", bus.r15, 16'h1234);
        issue(3'b011, 16'h8000, 16'hFFFF);
        wait_done(1, n);
        chk("div_ovf.of", bus.of, 1'b1);
        chk("div_ovf.out", bus.out, 16'h8000);
        chk("div_ovf.r15", bus.r15, 16'h0000);
        chk("div_ovf.dz", bus.dz, 1'b0);
`else
        issue(3'b011, 16'h0009, 16'h0003);
        wait_done(1, n);
        chk("nodiv.lat", n, 32'd1);
        chk("nodiv.ill", bus.ill, 1'b1);
        chk("nodiv.out", bus.out, 16'h0000);
        chk("nodiv.r15", bus.r15, 16'h0000);
        chk("nodiv.dz", bus.dz, 1'b0);
`endif

        issue(3'b100, 16'h00FF, 16'h0F0F);
        chk("and.out", bus.out, 16'h000F);
        chk("and.ill", bus.ill, 1'b0);

        issue(3'b111, 16'h0005, 16'h0006);
        wait_done(1, n);
        chk("ill.lat", n, 32'd1);
        chk("ill.ill", bus.ill, 1'b1);
        chk("ill.out", bus.out, 16'h0000);
        chk("ill.r15", bus.r15, 16'h0000);

        issue(3'b010, 16'h0002, 16'h0003);
        wait_done(1, n);
        chk("mul_small.out", bus.out, 16'h0006);
        chk("mul_small.ill", bus.ill, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
